hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller. Successor to the fixed-depth controller interface:
//  tracks in-flight destinations over NUM_FWD stages, issues per-operand bypass selects,
//  detects load-use and multi-cycle (mul/div) hazards, and flushes on branch mispredict.
//  Sits beside Decode; drives stall/flush to Fetch/Decode and bypass selects to Decode.
// PARAMETERS
//  NUM_FWD    2   downstream stages with forwardable results (entry 0 = Execute, N-1 = oldest)
//  REG_ADDR_W 5   register address width; register 0 never creates a hazard
//  MD_CNT_W   6   mul/div latency counter width (max latency 2**MD_CNT_W-1)
// PORTS
//  clk              in   1           clock
//  rst              in   1           async reset, active-high
//  dec_valid        in   1           Decode holds a valid instruction
//  dec_rs1/dec_rs2  in   REG_ADDR_W  source registers
//  dec_rs1_used/rs2 in   1           source actually read
//  dec_rd           in   REG_ADDR_W  destination register
//  dec_rd_we        in   1           instruction writes dec_rd
//  dec_is_load      in   1           instruction is a load (result ready one stage late)
//  dec_is_md        in   1           instruction uses the mul/div unit
//  dec_md_latency   in   MD_CNT_W    mul/div latency in cycles (>=1)
//  br_mispredict    in   1           Execute reports mispredicted branch this cycle
//  stall_fetch      out  1           hold Fetch PC
//  stall_decode     out  1           hold Decode register, inject bubble downstream
//  flush_fetch      out  1           invalidate Fetch output
//  flush_decode     out  1           invalidate Decode instruction
//  op1_bypass_sel   out  BYP_W       BypassSel for rs1 (BYP_W=$clog2(NUM_FWD+1))
//  op2_bypass_sel   out  BYP_W       BypassSel for rs2
//  md_busy          out  1           mul/div unit occupied
// BEHAVIOUR
//  State: entry[NUM_FWD] {valid, rd, is_load}; md_cnt (MD_CNT_W); md_rd; md_rd_we.
//  Reset: all entry.valid=0, md_cnt=0 -> all outputs 0, selects BYP_NONE, irrespective of dec_*.
//  dispatch = dec_valid & ~stall_decode & ~br_mispredict.
//  Every cycle entries shift: entry[i+1]<=entry[i]; entry[0]<={dispatch&dec_rd_we&(dec_rd!=0), dec_rd, dec_is_load}.
//  Oldest entry drops off (written back; regfile is write-through, no bypass needed beyond N-1).
//  Bypass: for each used rs!=0, youngest matching valid entry i selects BYP_STAGE(i); none -> BYP_NONE.
//   Unused source or rs==0 -> BYP_NONE. Combinational from state + dec_*.
//  Load-use: entry[0].valid & entry[0].is_load & rd matches used rs -> stall (1 cycle; next cycle
//   the load is entry[1] and forwards). NUM_FWD==1: load in entry[0] stalls; data via regfile next cycle.
//  Mul/div: on dispatch with dec_is_md: md_cnt<=dec_md_latency, md_rd<=dec_rd, md_rd_we<=dec_rd_we.
//   md_cnt!=0 decrements each cycle; md_busy=(md_cnt!=0). Result written to regfile on 1->0 cycle.
//   While busy: stall if dec_is_md, or used rs==md_rd (md_rd_we, !=0), or dec_rd==md_rd (WAW).
//   md op never enters entry[] (entry[0] gets valid=0 for it).
//  stall = dec_valid & (load_use | md_hazard); stall_fetch=stall_decode=stall & ~br_mispredict.
//  Mispredict priority: flush_fetch=flush_decode=br_mispredict; stalls forced 0; no dispatch; in-flight
//   entries and md_cnt untouched (all older than branch). Mispredict during stall: stall released, flushed.
//  Simultaneous hazards: single stall; selects still driven but meaningless while stalled.
//  Reset mid-operation: async clear of entries and md_cnt; busy unit result abandoned.
// STRUCTURE
//  PipelineTypes: BypassSel enum (BYP_NONE=0, BYP_STAGE(i)=i+1), HazardEntry struct {valid,rd,is_load}.
//  BasicTypes: RegAddrPath sized by REG_ADDR_W.
//  Sub-module md_busy_tracker: md_cnt/md_rd/md_rd_we, md_busy, md_hazard(rs1,rs2,rd,is_md).
//  Top: entry shift register, per-operand priority select (shared function), stall/flush logic.
// TESTING
//  1 Reset asserted mid-sequence, dec_valid=1 rs1=3 -> all outputs 0, selects BYP_NONE same cycle.
//  2 ADD x5; next ADD rs1=x5 -> op1_bypass_sel=BYP_STAGE(0); two cycles later rs2=x5 -> BYP_STAGE(1).
//  3 LW x7; next ADD rs1=x7 -> stall 1 cycle, then op1_bypass_sel=BYP_STAGE(1), no further stall.
//  4 DIV x9 latency 10; ADD rs2=x9 next -> stall exactly 10 cycles, md_busy drops same cycle stall drops.
//  5 LW x4 then ADD rs1=x4 with br_mispredict in stall cycle -> stall 0, flush_fetch/decode 1, entry[0] empty next.
//  6 rs1=rs2=x0 with writes to x0 in flight -> no stall, both BYP_NONE; NUM_FWD=1 and 3 rerun 2-3.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared defaults, register address type and bypass select encoding
package hazard_ctrl_unit_pkg;
  localparam int DEF_NUM_FWD = 2;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MD_CNT_W = 6;
  typedef logic [DEF_REG_ADDR_W-1:0] RegAddrPath;
  localparam int BYP_NONE = 0;
  function automatic int bypStage(input int i);
    return i + 1;
  endfunction
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: Decode/Execute-facing signals of the hazard controller
interface hazard_ctrl_unit_if
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MD_CNT_W = DEF_MD_CNT_W
) ();
  localparam int BYP_W = $clog2(NUM_FWD + 1);
  logic dec_valid;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic dec_rs1_used;
  logic dec_rs2_used;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic dec_rd_we;
  logic dec_is_load;
  logic dec_is_md;
  logic [MD_CNT_W-1:0] dec_md_latency;
  logic br_mispredict;
  logic stall_fetch;
  logic stall_decode;
  logic flush_fetch;
  logic flush_decode;
  logic [BYP_W-1:0] op1_bypass_sel;
  logic [BYP_W-1:0] op2_bypass_sel;
  logic md_busy;
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_rd_we,
           dec_is_load, dec_is_md, dec_md_latency, br_mispredict,
    input  stall_fetch, stall_decode, flush_fetch, flush_decode, op1_bypass_sel,
           op2_bypass_sel, md_busy
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_rd_we,
           dec_is_load, dec_is_md, dec_md_latency, br_mispredict,
    output stall_fetch, stall_decode, flush_fetch, flush_decode, op1_bypass_sel,
           op2_bypass_sel, md_busy
  );
endinterface

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// md_busy_tracker: occupancy counter and hazard detection for the multi-cycle mul/div unit
module md_busy_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MD_CNT_W-1:0]   latency,
  input  logic                  isMd,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rdWe,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1Used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2Used,
  output logic                  busy,
  output logic                  hazard
);
  logic [MD_CNT_W-1:0] mdCnt;
  logic [REG_ADDR_W-1:0] mdRd;
  logic mdRdWe;
  logic live;
  // Load the latency on issue, otherwise count down to the writeback cycle (1 -> 0).
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mdCnt <= '0;
      mdRd <= '0;
      mdRdWe <= 1'b0;
    end else if (start) begin
      mdCnt <= latency;
      mdRd <= rd;
      mdRdWe <= rdWe;
    end else if (mdCnt != '0) mdCnt <= mdCnt - MD_CNT_W'(1);
  // A busy unit blocks another md op, readers of its pending result and later writers of the same register.
  always_comb begin
    busy = mdCnt != '0;
    live = mdRdWe && mdRd != '0;
    hazard = busy && (isMd || (live && ((rs1Used && rs1 == mdRd) || (rs2Used && rs2 == mdRd) || (rdWe && rd == mdRd))));
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: bypass selection, load-use and mul/div stalls, and mispredict flush for Decode
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MD_CNT_W = DEF_MD_CNT_W
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_unit_if.slave bus
);
  localparam int BYP_W = $clog2(NUM_FWD + 1);
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic isLoad;
  } HazardEntry;
  HazardEntry [NUM_FWD-1:0] entries;
  HazardEntry newEntry;
  logic dispatch, loadUse, mdHazard, mdBusy, stall;
  function automatic logic [BYP_W-1:0] bypassFor(input logic used, input logic [REG_ADDR_W-1:0] rs,
                                                 input HazardEntry [NUM_FWD-1:0] e);
    logic [BYP_W-1:0] sel;
    sel = BYP_W'(BYP_NONE);
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (used && rs != '0 && e[i].valid && e[i].rd == rs) sel = BYP_W'(bypStage(i));
    return sel;
  endfunction
  md_busy_tracker #(.REG_ADDR_W(REG_ADDR_W), .MD_CNT_W(MD_CNT_W)) mdTracker (
    .clk(clk),
    .rst(rst),
    .start(dispatch && bus.dec_is_md),
    .latency(bus.dec_md_latency),
    .isMd(bus.dec_is_md),
    .rd(bus.dec_rd),
    .rdWe(bus.dec_rd_we),
    .rs1(bus.dec_rs1),
    .rs1Used(bus.dec_rs1_used),
    .rs2(bus.dec_rs2),
    .rs2Used(bus.dec_rs2_used),
    .busy(mdBusy),
    .hazard(mdHazard)
  );
  // Stall/dispatch decision; a mispredict overrides any stall and kills the Decode instruction.
  always_comb begin
    loadUse = entries[0].valid && entries[0].isLoad &&
              ((bus.dec_rs1_used && bus.dec_rs1 == entries[0].rd) || (bus.dec_rs2_used && bus.dec_rs2 == entries[0].rd));
    stall = bus.dec_valid && (loadUse || mdHazard) && !bus.br_mispredict;
    dispatch = bus.dec_valid && !stall && !bus.br_mispredict;
    newEntry = '{valid: dispatch && bus.dec_rd_we && bus.dec_rd != '0 && !bus.dec_is_md,
                 rd: bus.dec_rd, isLoad: bus.dec_is_load};
  end
  // Age in-flight destinations one stage per cycle; the oldest falls off into the write-through regfile.
  always_ff @(posedge clk or posedge rst)
    if (rst) entries <= '0;
    else begin
      for (int i = NUM_FWD - 1; i > 0; i--) entries[i] <= entries[i-1];
      entries[0] <= newEntry;
    end
  // Drive control and per-operand youngest-match bypass selects.
  always_comb begin
    bus.stall_fetch = stall;
    bus.stall_decode = stall;
    bus.flush_fetch = bus.br_mispredict;
    bus.flush_decode = bus.br_mispredict;
    bus.md_busy = mdBusy;
    bus.op1_bypass_sel = bypassFor(bus.dec_rs1_used, bus.dec_rs1, entries);
    bus.op2_bypass_sel = bypassFor(bus.dec_rs2_used, bus.dec_rs2, entries);
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed scoreboard bench driving NUM_FWD=1,2,3 controllers in lockstep
module tb_hazard_ctrl_unit;
  import hazard_ctrl_unit_pkg::*;
  typedef struct {
    string tag;
    logic [4:0] ctl;
    logic [2:0][1:0] s1;
    logic [2:0][1:0] s2;
  } exp_t;
  localparam logic [4:0] C0 = 5'b00000, CST = 5'b11000, CFL = 5'b00110, CB = 5'b00001,
                         CSTB = 5'b11001, CFLB = 5'b00111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv, u1, u2, we, ld, md, br;
  RegAddrPath rs1, rs2, rd;
  logic [5:0] lat;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  hazard_ctrl_unit_if #(.NUM_FWD(1)) b1 ();
  hazard_ctrl_unit_if #(.NUM_FWD(2)) b2 ();
  hazard_ctrl_unit_if #(.NUM_FWD(3)) b3 ();
  assign {b1.dec_valid, b1.dec_rs1, b1.dec_rs1_used, b1.dec_rs2, b1.dec_rs2_used, b1.dec_rd, b1.dec_rd_we,
          b1.dec_is_load, b1.dec_is_md, b1.dec_md_latency, b1.br_mispredict} = {dv, rs1, u1, rs2, u2, rd, we, ld, md, lat, br};
  assign {b2.dec_valid, b2.dec_rs1, b2.dec_rs1_used, b2.dec_rs2, b2.dec_rs2_used, b2.dec_rd, b2.dec_rd_we,
          b2.dec_is_load, b2.dec_is_md, b2.dec_md_latency, b2.br_mispredict} = {dv, rs1, u1, rs2, u2, rd, we, ld, md, lat, br};
  assign {b3.dec_valid, b3.dec_rs1, b3.dec_rs1_used, b3.dec_rs2, b3.dec_rs2_used, b3.dec_rd, b3.dec_rd_we,
          b3.dec_is_load, b3.dec_is_md, b3.dec_md_latency, b3.br_mispredict} = {dv, rs1, u1, rs2, u2, rd, we, ld, md, lat, br};
  hazard_ctrl_unit #(.NUM_FWD(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_ctrl_unit #(.NUM_FWD(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
  hazard_ctrl_unit #(.NUM_FWD(3)) d3 (.clk(clk), .rst(rst), .bus(b3));
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic setI(input logic v, input RegAddrPath a, input logic ua, input RegAddrPath b, input logic ub,
                      input RegAddrPath d, input logic w, input logic l, input logic m, input logic [5:0] t);
    {dv, rs1, u1, rs2, u2, rd, we, ld, md, lat} = {v, a, ua, b, ub, d, w, l, m, t};
  endtask
  task automatic step(input string tag, input logic [4:0] ctl, input logic [1:0] a1, a2, a3,
                      input logic [1:0] c1, c2, c3);
    exp_t e;
    q.push_back('{tag, ctl, {a3, a2, a1}, {c3, c2, c1}});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, "/ctl_n1"}, {b1.stall_fetch, b1.stall_decode, b1.flush_fetch, b1.flush_decode, b1.md_busy}, e.ctl);
      chk({e.tag, "/ctl_n2"}, {b2.stall_fetch, b2.stall_decode, b2.flush_fetch, b2.flush_decode, b2.md_busy}, e.ctl);
      chk({e.tag, "/ctl_n3"}, {b3.stall_fetch, b3.stall_decode, b3.flush_fetch, b3.flush_decode, b3.md_busy}, e.ctl);
      chk({e.tag, "/op1_n1"}, {4'b0, b1.op1_bypass_sel}, {3'b0, e.s1[0]});
      chk({e.tag, "/op1_n2"}, {3'b0, b2.op1_bypass_sel}, {3'b0, e.s1[1]});
      chk({e.tag, "/op1_n3"}, {3'b0, b3.op1_bypass_sel}, {3'b0, e.s1[2]});
      chk({e.tag, "/op2_n1"}, {4'b0, b1.op2_bypass_sel}, {3'b0, e.s2[0]});
      chk({e.tag, "/op2_n2"}, {3'b0, b2.op2_bypass_sel}, {3'b0, e.s2[1]});
      chk({e.tag, "/op2_n3"}, {3'b0, b3.op2_bypass_sel}, {3'b0, e.s2[2]});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    br = 1'b0;
    setI(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    step("reset", C0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    setI(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    step("add_x5", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    step("byp_stage0", C0, 1, 1, 1, 0, 0, 0);
    setI(1, 0, 1, 5, 1, 8, 1, 0, 0, 0);
    step("byp_stage1", C0, 0, 0, 0, 0, 2, 2);
    setI(1, 8, 0, 5, 1, 0, 0, 0, 0, 0);
    step("byp_stage2_unused", C0, 0, 0, 0, 0, 0, 3);
    setI(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    step("add_x10", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 10, 1, 0, 0, 10, 1, 0, 0, 0);
    step("add_x10_again", C0, 1, 1, 1, 0, 0, 0);
    setI(1, 10, 1, 10, 1, 0, 0, 0, 0, 0);
    step("youngest_wins", C0, 1, 1, 1, 1, 1, 1);
    setI(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
    step("lw_x7", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 7, 1, 0, 0, 11, 1, 0, 0, 0);
    step("load_use_stall", CST, 1, 1, 1, 0, 0, 0);
    step("load_use_release", C0, 0, 2, 2, 0, 0, 0);
    setI(1, 7, 1, 11, 1, 12, 1, 0, 0, 0);
    step("after_load_use", C0, 0, 0, 3, 1, 1, 1);
    setI(1, 0, 0, 0, 0, 9, 1, 0, 1, 10);
    step("div_x9", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 0, 9, 1, 13, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step($sformatf("md_stall%0d", i), CSTB, 0, 0, 0, 0, 0, 0);
    step("md_release", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    step("lw_x4", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 4, 1, 0, 0, 14, 1, 0, 0, 0);
    br = 1'b1;
    step("mispredict_in_stall", CFL, 1, 1, 1, 0, 0, 0);
    br = 1'b0;
    setI(1, 4, 1, 14, 1, 0, 0, 0, 0, 0);
    step("after_flush", C0, 0, 2, 2, 0, 0, 0);
    setI(1, 0, 0, 0, 0, 9, 1, 0, 1, 3);
    step("div_lat3", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 0, 0, 0, 22, 1, 0, 1, 20);
    br = 1'b1;
    step("mispredict_md_busy", CFLB, 0, 0, 0, 0, 0, 0);
    br = 1'b0;
    setI(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("md_busy_2", CB, 0, 0, 0, 0, 0, 0);
    step("md_busy_1", CB, 0, 0, 0, 0, 0, 0);
    step("md_idle", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    step("lw_x0", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    step("x0_no_hazard", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step("add_x3", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 0, 0, 0, 0, 20, 1, 0, 1, 5);
    step("div_x20", C0, 0, 0, 0, 0, 0, 0);
    setI(1, 3, 1, 20, 1, 21, 1, 0, 1, 2);
    step("pre_reset", CSTB, 0, 2, 2, 0, 0, 0);
    rst = 1'b1;
    step("mid_reset", C0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("post_reset", C0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
